add_arbiter: RTL and testbench
==============================

# add_arbiter

Round-robin arbiter and sequencer that shares one combinational WIDTH-bit adder between two requesters. Each requester presents an operand pair over a valid/ready handshake. The block grants one requester, drives the shared adder from registered operands, and captures sum and carry. It then returns the result, tagged with the requester id, over a valid/ready response channel. The block sits between the I/O decode logic and the shared adder datapath in the tile top level.

## Interface
- WIDTH, 8, operand and sum width in bits

- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  requester k has an operand pair
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  requester k operands
- req0_ready / req1_ready  out  1  requester k operand pair accepted this cycle
- add_a, add_b  out  WIDTH  operands driven to the shared adder
- add_sum  in  WIDTH  adder sum, combinational from add_a/add_b
- add_cout  in  1  adder carry-out
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_sum  out  WIDTH  registered sum
- rsp_carry  out  1  registered carry-out
- rsp_id  out  1  requester that issued the result (0 or 1)
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - The arbiter selects a winner among the asserted reqk_valid.
  - If only one requester is valid, it wins regardless of the pointer.
  - If both are valid, the winner is the requester that does not match last_grant.
  - reqk_ready = (state==IDLE) & grant_k. This is combinational, and at most one ready is high.
  - On valid&ready: capture a/b into op_a/op_b, capture k into id, set last_grant=k, go to EXEC.
- EXEC:
  - add_a=op_a and add_b=op_b.
  - Capture add_sum into rsp_sum and add_cout into rsp_carry.
  - Set rsp_valid=1 and go to RESP.
- RESP:
  - Hold rsp_sum, rsp_carry and rsp_id stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready: clear rsp_valid and go to IDLE.
- add_a and add_b are 0 in every state except EXEC, which keeps the shared adder quiet.
- Width rule: the result is WIDTH+1 bits, {rsp_carry, rsp_sum} = a+b. Overflow wraps the sum and sets the carry. There is no saturation.
- Requesters must hold valid and operands stable until ready. A valid that drops before ready causes no transfer and no state change.
- New requests are ignored outside IDLE. No reqk_ready is asserted while busy.

## Timing
- Reset values: state=IDLE, last_grant=1 (so req0 wins the first tie), req0_ready=0, req1_ready=0 (while no valid), add_a=0, add_b=0, rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, busy=0.
- Latency from the accept edge (cycle N, valid&ready sampled):
  - EXEC in cycle N+1.
  - rsp_valid high in cycle N+2.
- If rsp_ready is high in the first RESP cycle, state is IDLE in N+3. The next accept can then occur in N+3, giving a peak throughput of one operation per 3 cycles.
- Response backpressure: RESP is held indefinitely with its outputs stable.
- Reset mid-operation (any state): the in-flight transaction is discarded immediately and all outputs take their reset values. No response is ever issued for the discarded transaction.
- Simultaneous valid on both requesters in consecutive transactions: grants alternate 0,1,0,1,…

## Test plan
- Single request: req0 a=0x12, b=0x34 with rsp_ready=1 → req0_ready in cycle N; rsp_valid in N+2 with sum=0x46, carry=0, id=0; busy high for N+1..N+2.
- Overflow: req1 a=0xFF, b=0x01 → sum=0x00, carry=1, id=1. Also a=0x80, b=0x80 → sum=0x00, carry=1.
- Contention: both valid continuously, with distinct operands, for 6 transactions after reset → rsp_id sequence is 0,1,0,1,0,1 and each sum matches its requester's operands.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → outputs stable, req0_ready and req1_ready stay 0, add_a and add_b stay 0; rsp_ready=1 → IDLE on the next cycle.
- Reset in EXEC and in RESP: assert rst_n=0 asynchronously → rsp_valid, busy, add_a and add_b drop to 0 without waiting for a clock edge; after release, req0 wins the first tie.
- Valid withdrawn: req0_valid pulses while busy, then drops before IDLE → no transfer, no extra response.

Source files
------------

// File: rtl/add_arbiter_if.sv
// -----------------------------------------------------------------------------
// add_arbiter_if
//
// Bundles every non-clock signal of add_arbiter: two requester operand
// channels, the shared-adder port and the tagged response channel.
//
//   slave  : the arbiter side (add_arbiter uses this modport)
//   master : the environment side (requesters, shared adder, result consumer)
//
// Signal summary (directions as seen by the arbiter):
//   req0_valid/req1_valid  in   requester k has an operand pair
//   req0_a/b, req1_a/b     in   requester k operands (WIDTH bits)
//   req0_ready/req1_ready  out  requester k operand pair accepted this cycle
//   add_a, add_b           out  operands to the shared adder (0 unless busy adding)
//   add_sum, add_cout      in   combinational adder result
//   rsp_valid              out  result available
//   rsp_ready              in   consumer accepts result
//   rsp_sum, rsp_carry     out  registered sum and carry-out
//   rsp_id                 out  requester that issued the result
//   busy                   out  arbiter is not idle
// -----------------------------------------------------------------------------
interface add_arbiter_if #(
  parameter int unsigned WIDTH = 8
);

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_carry;
  logic             rsp_id;

  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  add_sum, add_cout,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output add_a, add_b,
    output rsp_valid, rsp_sum, rsp_carry, rsp_id,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output add_sum, add_cout,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  add_a, add_b,
    input  rsp_valid, rsp_sum, rsp_carry, rsp_id,
    input  busy
  );

endinterface : add_arbiter_if

// File: rtl/add_arbiter.sv
// -----------------------------------------------------------------------------
// add_arbiter
//
// Round-robin arbiter/sequencer sharing one external combinational adder
// between two requesters. A granted operand pair is registered, presented to
// the adder for exactly one cycle (EXEC), and the sum/carry are captured and
// returned with the requester id over a valid/ready response channel.
//
// Ports:
//   clk    in  clock, all state updates on the rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    add_arbiter_if.slave, see add_arbiter_if for the signal list
//
// Flow: IDLE --accept--> EXEC --capture--> RESP --rsp_ready--> IDLE
// Peak throughput is one operation every three cycles.
// -----------------------------------------------------------------------------
module add_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  add_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;   // requester granted most recently
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_carry_q;
  logic             rsp_id_q;
  logic             busy_q;

  logic             grant0;
  logic             grant1;
  logic             accept0;
  logic             accept1;

  // ---------------------------------------------------------------------------
  // Arbitration. A lone requester always wins; on a tie the requester that
  // was not served last wins, so back-to-back ties alternate 0,1,0,1...
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant0 = last_grant;
      grant1 = !last_grant;
    end else begin
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid;
    end
  end

  // Ready is combinational so a request can be accepted in its first IDLE
  // cycle; outside IDLE both readies are held low and new requests wait.
  assign bus.req0_ready = (state == IDLE) && grant0;
  assign bus.req1_ready = (state == IDLE) && grant1;

  assign accept0 = bus.req0_valid && bus.req0_ready;
  assign accept1 = bus.req1_valid && bus.req1_ready;

  // The shared adder sees our operands only during EXEC; at all other times
  // it is driven with zeros so it does not toggle.
  assign bus.add_a = (state == EXEC) ? op_a : '0;
  assign bus.add_b = (state == EXEC) ? op_b : '0;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.busy      = busy_q;

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand and result registers are reset too, because the
      // response fields are visible outputs with defined reset values and a
      // reset must discard any in-flight transaction completely.
      state       <= IDLE;
      last_grant  <= 1'b1;      // req0 wins the first tie after reset
      op_a        <= '0;
      op_b        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept0 || accept1) begin
            op_a       <= accept1 ? bus.req1_a : bus.req0_a;
            op_b       <= accept1 ? bus.req1_b : bus.req0_b;
            rsp_id_q   <= accept1;
            last_grant <= accept1;
            busy_q     <= 1'b1;
            state      <= EXEC;
          end
        end

        EXEC: begin
          // The adder is combinational from add_a/add_b, which carry op_a/op_b
          // in this state, so its result is stable by the end of the cycle.
          rsp_sum_q   <= bus.add_sum;
          rsp_carry_q <= bus.add_cout;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end

        RESP: begin
          // Response fields are untouched here, so they stay stable for as
          // long as the consumer applies backpressure.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol properties.
  // ---------------------------------------------------------------------------
  a_one_ready: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(bus.req0_ready && bus.req1_ready)
  );

  a_no_ready_when_busy: assert property (
    @(posedge clk) disable iff (!rst_n)
    bus.busy |-> !(bus.req0_ready || bus.req1_ready)
  );

  a_adder_quiet: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state != EXEC) |-> (bus.add_a == '0 && bus.add_b == '0)
  );

  a_rsp_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    (bus.rsp_valid && !bus.rsp_ready) |=>
      (bus.rsp_valid && $stable(bus.rsp_sum) && $stable(bus.rsp_carry) && $stable(bus.rsp_id))
  );

endmodule : add_arbiter

// File: tb/tb_add_arbiter.sv
// -----------------------------------------------------------------------------
// tb_add_arbiter
//
// Self-checking bench for add_arbiter. The bench provides the shared adder,
// drives both requesters and the response consumer, and keeps a transaction
// level reference model: whenever the model decides a request is accepted it
// pushes the expected {id, carry, sum} into a scoreboard queue, and an
// independent monitor pops and compares on every response handshake.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_add_arbiter;

  localparam int W = 8;

  typedef struct packed {
    logic         id;
    logic         carry;
    logic [W-1:0] sum;
  } rsp_t;

  logic clk;
  logic rst_n;

  logic         req_valid [2];
  logic [W-1:0] req_a     [2];
  logic [W-1:0] req_b     [2];
  logic         rsp_ready_r;
  int           rr_mode;         // 0: hold rsp_ready low, 1: high, 2: random

  int n_pass;
  int n_total;

  rsp_t exp_q[$];

  // Reference model state.
  int           m_phase;         // 0: idle, 1: adder cycle, 2: result pending
  bit           m_last;          // requester served most recently
  rsp_t         m_cur;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;

  add_arbiter_if #(.WIDTH(W)) bus ();

  add_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.req0_valid = req_valid[0];
  assign bus.req0_a     = req_a[0];
  assign bus.req0_b     = req_b[0];
  assign bus.req1_valid = req_valid[1];
  assign bus.req1_a     = req_a[1];
  assign bus.req1_b     = req_b[1];
  assign bus.rsp_ready  = rsp_ready_r;

  // Shared combinational adder.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Consumer: the only writer of rsp_ready.
  initial begin
    rsp_ready_r = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       rsp_ready_r = 1'b0;
        1:       rsp_ready_r = 1'b1;
        default: rsp_ready_r = ($urandom_range(0, 99) < 60);
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: arbitration decision, latency and per-cycle outputs.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : model
    logic [W:0] s;
    bit         has;
    bit         win;
    if (!rst_n) begin
      m_phase = 0;
      m_last  = 1'b1;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: begin
          has = req_valid[0] || req_valid[1];
          if (req_valid[0] && req_valid[1]) win = !m_last;
          else                              win = req_valid[1];
          check("idle_req0_ready", bus.req0_ready, has && !win);
          check("idle_req1_ready", bus.req1_ready, has && win);
          check("idle_busy",       bus.busy, 0);
          check("idle_rsp_valid",  bus.rsp_valid, 0);
          check("idle_add_a",      bus.add_a, 0);
          check("idle_add_b",      bus.add_b, 0);
          if (has) begin
            s       = {1'b0, req_a[win]} + {1'b0, req_b[win]};
            m_cur   = '{id: win, carry: s[W], sum: s[W-1:0]};
            m_a     = req_a[win];
            m_b     = req_b[win];
            m_last  = win;
            exp_q.push_back(m_cur);
            m_phase = 1;
          end
        end
        1: begin
          check("exec_busy",      bus.busy, 1);
          check("exec_ready",     {bus.req0_ready, bus.req1_ready}, 0);
          check("exec_rsp_valid", bus.rsp_valid, 0);
          check("exec_add_a",     bus.add_a, m_a);
          check("exec_add_b",     bus.add_b, m_b);
          m_phase = 2;
        end
        default: begin
          check("resp_busy",      bus.busy, 1);
          check("resp_ready",     {bus.req0_ready, bus.req1_ready}, 0);
          check("resp_rsp_valid", bus.rsp_valid, 1);
          check("resp_add",       {bus.add_a, bus.add_b}, 0);
          check("resp_hold",      {bus.rsp_id, bus.rsp_carry, bus.rsp_sum}, m_cur);
          if (rsp_ready_r) m_phase = 0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: compares every completed response handshake.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    rsp_t e;
    if (rst_n && bus.rsp_valid && rsp_ready_r) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_sum",   bus.rsp_sum,   e.sum);
        check("rsp_carry", bus.rsp_carry, e.carry);
        check("rsp_id",    bus.rsp_id,    e.id);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge
  // (plus 1 time unit when the valid is dropped).
  task automatic send(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit keep);
    bit ok;
    #1;
    req_valid[k] = 1'b1;
    req_a[k]     = a;
    req_b[k]     = b;
    ok           = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = (k == 0) ? bus.req0_ready : bus.req1_ready;
      @(posedge clk);
    end
    check("send_handshake", ok, 1);
    if (!keep) begin
      #1;
      req_valid[k] = 1'b0;
    end
  endtask

  task automatic drive_random(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(k, W'($urandom), W'($urandom), 1'b0);
    end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 50 && !idle; c++) begin
      @(negedge clk);
      idle = (m_phase == 0);
    end
    check("idle_timeout", idle, 1);
    @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_busy"},      bus.busy, 0);
    check({tag, "_add_a"},     bus.add_a, 0);
    check({tag, "_add_b"},     bus.add_b, 0);
    check({tag, "_rsp_sum"},   bus.rsp_sum, 0);
    check({tag, "_rsp_carry"}, bus.rsp_carry, 0);
    check({tag, "_rsp_id"},    bus.rsp_id, 0);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit seen;
    n_pass  = 0;
    n_total = 0;
    rr_mode = 1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      req_a[k]     = '0;
      req_b[k]     = '0;
    end

    // Reset values.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("por");
    check("por_ready", {bus.req0_ready, bus.req1_ready}, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);

    // Single request and the two overflow cases.
    send(0, 8'h12, 8'h34, 1'b0);
    wait_idle();
    send(1, 8'hFF, 8'h01, 1'b0);
    wait_idle();
    send(0, 8'h80, 8'h80, 1'b0);
    wait_idle();

    // Contention right after reset: ids must run 0,1,0,1,0,1.
    reset_pulse();
    fork
      begin
        for (int i = 0; i < 3; i++) send(0, 8'h10 + 8'(i), 8'h01 + 8'(i), i < 2);
      end
      begin
        for (int i = 0; i < 3; i++) send(1, 8'hA0 + 8'(i), 8'h70 + 8'(i), i < 2);
      end
    join
    wait_idle();

    // Backpressure for 5 cycles; a req0 pulse while busy must be ignored.
    rr_mode = 0;
    @(posedge clk);
    send(0, 8'h5A, 8'hC3, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = bus.rsp_valid;
    end
    check("bp_rsp_valid_seen", seen, 1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b1;
    req_a[0]     = 8'h11;
    req_b[0]     = 8'h22;
    repeat (2) @(posedge clk);
    #1 req_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    rr_mode = 1;
    wait_idle();
    repeat (3) @(posedge clk);

    // Reset while in EXEC.
    rr_mode = 0;
    @(posedge clk);
    send(0, 8'h33, 8'h44, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_exec");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Reset while in RESP.
    @(posedge clk);
    send(1, 8'h77, 8'h99, 1'b0);
    @(posedge clk);
    #2;
    check("pre_rst_resp_valid", bus.rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_resp");
    rr_mode = 1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // First tie after reset goes to req0.
    @(posedge clk);
    #1;
    req_valid[0] = 1'b1; req_a[0] = 8'h01; req_b[0] = 8'h02;
    req_valid[1] = 1'b1; req_a[1] = 8'h03; req_b[1] = 8'h04;
    @(negedge clk);
    check("tie_after_reset", {bus.req0_ready, bus.req1_ready}, 2'b10);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = bus.req1_ready;
      @(posedge clk);
    end
    check("tie_req1_served", seen, 1);
    #1 req_valid[1] = 1'b0;
    wait_idle();

    // Randomised traffic with random consumer backpressure.
    rr_mode = 2;
    fork
      drive_random(0, 25);
      drive_random(1, 25);
    join
    rr_mode = 1;
    wait_idle();
    repeat (4) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_add_arbiter
